// File: rtl/vga_timing_monitor.sv
// rtl/vga_timing_monitor.sv - VGA stream geometry checker with per-frame checksum and lock status
module vga_timing_monitor #(
  parameter int H_ACTIVE        = 640,
  parameter int H_TOTAL         = 800,
  parameter int H_SYNC          = 96,
  parameter int V_ACTIVE        = 480,
  parameter int V_TOTAL         = 525,
  parameter int V_SYNC          = 2,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        pll_clk,
  input  logic        reset_N,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        clear_errors,
  output logic [11:0] h_total_meas,
  output logic [11:0] h_active_meas,
  output logic [11:0] v_total_meas,
  output logic [11:0] v_active_meas,
  output logic [31:0] frame_sum,
  output logic        frame_done,
  output logic        locked,
  output logic [3:0]  err_flags
);

  typedef enum logic [1:0] {IDLE, CHECK, LOCKED} state_t;

  localparam logic [11:0] H_ACTIVE_C = 12'(H_ACTIVE);
  localparam logic [11:0] H_TOTAL_C  = 12'(H_TOTAL);
  localparam logic [11:0] H_SYNC_C   = 12'(H_SYNC);
  localparam logic [11:0] V_ACTIVE_C = 12'(V_ACTIVE);
  localparam logic [11:0] V_TOTAL_C  = 12'(V_TOTAL);
  localparam logic [11:0] V_SYNC_C   = 12'(V_SYNC);
  localparam logic [7:0]  LOCK_C     = 8'(LOCK_FRAMES);

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  state_t      state;
  logic [7:0]  good_cnt;
  logic        hs_q, vs_q, hs_d, vs_d, blank_q, clear_q;
  logic [7:0]  r_q, g_q, b_q;
  logic [11:0] line_cnt, hs_w, act_cnt, last_line, last_act;
  logic [11:0] v_cnt, v_act, vs_lines;
  logic [31:0] sum;
  logic        frame_err;

  // Edge detection works on the registered, polarity-normalised syncs
  logic        hs_lead, hs_fall, vs_lead, vs_fall, chk_en, line_act;
  logic [9:0]  pix;
  logic [11:0] v_act_now;
  logic [3:0]  err_set;
  logic        frame_bad;
  logic [7:0]  good_next;

  assign hs_lead   = hs_q & ~hs_d;
  assign hs_fall   = ~hs_q & hs_d;
  assign vs_lead   = vs_q & ~vs_d;
  assign vs_fall   = ~vs_q & vs_d;
  assign chk_en    = (state != IDLE);
  assign line_act  = (act_cnt != 12'd0);
  assign pix       = 10'(r_q) + 10'(g_q) + 10'(b_q);
  // The line closed by an HS edge coinciding with the VS edge still belongs to the old frame
  assign v_act_now = (hs_lead && line_act) ? sat_inc(v_act) : v_act;
  assign err_set[0] = chk_en & hs_lead & (line_cnt != H_TOTAL_C);
  assign err_set[1] = chk_en & hs_fall & (hs_w != H_SYNC_C);
  assign err_set[2] = chk_en & ((vs_lead & (v_cnt != V_TOTAL_C)) | (vs_fall & (vs_lines != V_SYNC_C)));
  assign err_set[3] = chk_en & ((hs_lead & line_act & (act_cnt != H_ACTIVE_C)) |
                                (vs_lead & (v_act_now != V_ACTIVE_C)));
  assign frame_bad = frame_err | (|err_set);
  assign good_next = (good_cnt >= LOCK_C) ? LOCK_C : good_cnt + 8'd1;

  // Register every input once; syncs are stored as "asserted" regardless of polarity
  always_ff @(posedge pll_clk or negedge reset_N) begin
    if (!reset_N) begin
      hs_q <= 1'b0; vs_q <= 1'b0; hs_d <= 1'b0; vs_d <= 1'b0;
      blank_q <= 1'b0; clear_q <= 1'b0;
      r_q <= '0; g_q <= '0; b_q <= '0;
    end else begin
      hs_q    <= (SYNC_ACTIVE_LOW != 0) ? ~vga_hs : vga_hs;
      vs_q    <= (SYNC_ACTIVE_LOW != 0) ? ~vga_vs : vga_vs;
      hs_d    <= hs_q;
      vs_d    <= vs_q;
      blank_q <= vga_blank_n;
      clear_q <= clear_errors;
      r_q     <= vga_r;
      g_q     <= vga_g;
      b_q     <= vga_b;
    end
  end

  // Per-line measurements: clocks per line, HS width and active pixels
  always_ff @(posedge pll_clk or negedge reset_N) begin
    if (!reset_N) begin
      line_cnt <= '0; hs_w <= '0; act_cnt <= '0; last_line <= '0; last_act <= '0;
    end else begin
      if (hs_lead) begin
        line_cnt  <= 12'd1;
        hs_w      <= 12'd1;
        act_cnt   <= blank_q ? 12'd1 : 12'd0;
        last_line <= line_cnt;
        if (line_act) last_act <= act_cnt;
      end else begin
        line_cnt <= sat_inc(line_cnt);
        if (hs_q) hs_w <= sat_inc(hs_w);
        if (blank_q) act_cnt <= sat_inc(act_cnt);
      end
    end
  end

  // Per-frame measurements: lines, VS width in lines, active lines, checksum, error latch
  always_ff @(posedge pll_clk or negedge reset_N) begin
    if (!reset_N) begin
      v_cnt <= '0; v_act <= '0; vs_lines <= '0; sum <= '0; frame_err <= 1'b0;
    end else if (vs_lead) begin
      v_cnt     <= hs_lead ? 12'd1 : 12'd0;
      v_act     <= '0;
      vs_lines  <= hs_lead ? 12'd1 : 12'd0;
      sum       <= blank_q ? 32'(pix) : 32'd0;
      frame_err <= 1'b0;
    end else begin
      if (hs_lead) v_cnt <= sat_inc(v_cnt);
      v_act <= v_act_now;
      if (hs_lead && vs_q) vs_lines <= sat_inc(vs_lines);
      if (blank_q) sum <= sum + 32'(pix);
      if (|err_set) frame_err <= 1'b1;
    end
  end

  // Frame evaluation, lock tracking and sticky error flags (a new set beats a clear)
  always_ff @(posedge pll_clk or negedge reset_N) begin
    if (!reset_N) begin
      state <= IDLE; good_cnt <= '0; locked <= 1'b0; frame_done <= 1'b0;
      h_total_meas <= '0; h_active_meas <= '0; v_total_meas <= '0; v_active_meas <= '0;
      frame_sum <= '0; err_flags <= '0;
    end else begin
      frame_done <= 1'b0;
      err_flags  <= (err_flags & ~{4{clear_q}}) | err_set;
      if (vs_lead) begin
        if (state == IDLE) begin
          state    <= CHECK;
          good_cnt <= '0;
        end else begin
          frame_done    <= 1'b1;
          h_total_meas  <= hs_lead ? line_cnt : last_line;
          h_active_meas <= (hs_lead && line_act) ? act_cnt : last_act;
          v_total_meas  <= v_cnt;
          v_active_meas <= v_act_now;
          frame_sum     <= sum;
          if (frame_bad) begin
            good_cnt <= '0;
            locked   <= 1'b0;
            state    <= CHECK;
          end else begin
            good_cnt <= good_next;
            if (good_next == LOCK_C) begin
              locked <= 1'b1;
              state  <= LOCKED;
            end else begin
              locked <= 1'b0;
              state  <= CHECK;
            end
          end
        end
      end
    end
  end

endmodule
